// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream loader; holds the core in reset while a host
// streams a big-endian program image, then releases it to fetch from the same array.
module imem_loader #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        cpu_rst,
    output logic        busy,
    output logic        err,
    output logic [15:0] ld_count,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_din
);

    // state     | meaning
    // S_IDLE    | core in reset, waiting for start
    // S_LOAD_HI | waiting for the even (high) byte of a word
    // S_LOAD_LO | waiting for the odd (low) byte; completes a word write
    // S_DRAIN   | image overflowed the array; discard bytes until ld_last
    // S_RUN     | image complete, core released
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_DRAIN,
        S_RUN
    } state_t;

    localparam logic [15:0] LP_DEPTH = 16'(DEPTH_WORDS);

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [7:0]    r_hi;
    logic          r_err;
    logic          r_cpu_rst;
    logic          r_ld_ready;
    logic          r_busy;
    logic [15:0]   r_cnt;
    logic [15:0]   r_mem [DEPTH_WORDS];

    logic          w_hs;
    logic          w_we;
    logic [15:0]   w_wdata;
    logic [15:0]   w_cnt_inc;
    logic          w_ptr_last;
    logic          w_unused_addr;

    assign w_hs       = ld_valid & r_ld_ready;
    assign w_we       = w_hs & (((r_state == S_LOAD_HI) & ld_last) | (r_state == S_LOAD_LO));
    assign w_wdata    = (r_state == S_LOAD_HI) ? {ld_data, 8'h00} : {r_hi, ld_data};
    assign w_cnt_inc  = (r_cnt == LP_DEPTH) ? r_cnt : r_cnt + 16'd1;
    assign w_ptr_last = &r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_hi       <= 8'h00;
            r_err      <= 1'b0;
            r_cnt      <= 16'h0000;
            r_cpu_rst  <= 1'b1;
            r_ld_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        r_state    <= S_LOAD_HI;
                        r_ptr      <= '0;
                        r_cnt      <= 16'h0000;
                        r_err      <= 1'b0;
                        r_cpu_rst  <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD_HI: begin
                    if (w_hs) begin
                        r_hi <= ld_data;
                        if (ld_last) begin
                            r_cnt      <= w_cnt_inc;
                            r_state    <= S_RUN;
                            r_cpu_rst  <= 1'b0;
                            r_ld_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= S_LOAD_LO;
                        end
                    end
                end
                S_LOAD_LO: begin
                    if (w_hs) begin
                        r_cnt <= w_cnt_inc;
                        // Pointer parks on the top word instead of wrapping onto word 0.
                        if (!w_ptr_last) begin
                            r_ptr <= r_ptr + AW'(1);
                        end
                        if (ld_last) begin
                            r_state    <= S_RUN;
                            r_cpu_rst  <= 1'b0;
                            r_ld_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end else if (w_ptr_last) begin
                            r_state <= S_DRAIN;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_LOAD_HI;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs && ld_last) begin
                        r_state    <= S_IDLE;
                        r_ld_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cpu_rst  <= 1'b1;
                    r_ld_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately left out of reset so an aborted load keeps what it wrote.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_ptr] <= w_wdata;
        end
    end

    assign i_din         = i_oe ? r_mem[i_addr[AW:1]] : 16'h0000;
    assign w_unused_addr = ^{i_addr[15:AW+1], i_addr[0]};

    assign ld_ready = r_ld_ready;
    assign busy     = r_busy;
    assign cpu_rst  = r_cpu_rst;
    assign err      = r_err;
    assign ld_count = r_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size and a 4-word instance share stimulus; results are
// compared against a byte-list model of the image and a table of constant expectations.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic [15:0] i_addr;
    logic        i_oe;

    logic        ld_ready, cpu_rst, busy, err;
    logic [15:0] ld_count, i_din;
    logic        ld_ready4, cpu_rst4, busy4, err4;
    logic [15:0] ld_count4, i_din4;

    int errors   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(4096), .AW(12)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst), .busy(busy), .err(err),
        .ld_count(ld_count), .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din)
    );

    imem_loader #(.DEPTH_WORDS(4), .AW(2)) dut4 (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready4),
        .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst4), .busy(busy4), .err(err4),
        .ld_count(ld_count4), .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din4)
    );

    typedef struct {
        int          n;
        logic [79:0] b;          // byte i at b[79-8*i -: 8]
        int          maxgap;
        int          cnt_big;
        int          cnt_small;
        bit          err_small;
        bit          cpu_rst_small;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Image-level model: words are big-endian byte pairs, odd tail zero-padded,
    // truncated to the array depth; overflow whenever bytes exceed 2*depth.
    function automatic void model(input logic [7:0] q[$], input int depth,
                                  output int cnt, output bit ovf, output logic [15:0] words[$]);
        int n;
        int nw;
        n   = q.size();
        ovf = (n > 2 * depth);
        nw  = (n + 1) / 2;
        cnt = (nw < depth) ? nw : depth;
        words.delete();
        for (int k = 0; k < cnt; k++) begin
            words.push_back({q[2*k], (2*k+1 < n) ? q[2*k+1] : 8'h00});
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int maxgap);
        int g;
        int waited;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        ld_valid = 1'b0;
        repeat (g) begin
            ld_data = 8'($urandom);
            ld_last = 1'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        waited   = 0;
        while (!ld_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ld_ready) begin
            n_checks++;
            errors++;
            $display("FAIL handshake_timeout: ld_ready stayed 0 for byte 0x%0h", b);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] q[$], input int maxgap);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], (i == q.size() - 1), maxgap);
        end
    endtask

    task automatic check_load(input logic [7:0] q[$], input string tag);
        int cb, cs;
        bit eb, es;
        logic [15:0] wb[$];
        logic [15:0] ws[$];
        model(q, 4096, cb, eb, wb);
        model(q, 4, cs, es, ws);
        chk({tag, "_cnt"},      32'(ld_count), 32'(cb));
        chk({tag, "_err"},      32'(err), 32'(eb));
        chk({tag, "_cpu_rst"},  32'(cpu_rst), 32'(eb));
        chk({tag, "_busy_rdy"}, {30'h0, busy, ld_ready}, 32'h0);
        chk({tag, "_cnt4"},     32'(ld_count4), 32'(cs));
        chk({tag, "_err4"},     32'(err4), 32'(es));
        chk({tag, "_cpu_rst4"}, 32'(cpu_rst4), 32'(es));
        chk({tag, "_busy_rdy4"}, {30'h0, busy4, ld_ready4}, 32'h0);
        i_oe = 1'b1;
        for (int k = 0; k < wb.size(); k++) begin
            i_addr = 16'(($urandom & 32'hE000) | (k << 1) | $urandom_range(0, 1));
            #1;
            chk({tag, "_rd"}, 32'(i_din), 32'(wb[k]));
        end
        for (int k = 0; k < ws.size(); k++) begin
            i_addr = 16'(($urandom & 32'hFFF8) | (k << 1) | $urandom_range(0, 1));
            #1;
            chk({tag, "_rd4"}, 32'(i_din4), 32'(ws[k]));
        end
        i_oe = 1'b0;
        #1;
        chk({tag, "_oe_off"}, {i_din, i_din4}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];

        vecs[0] = '{4,  80'h12345678_000000000000, 0, 2, 2, 1'b0, 1'b0};
        vecs[1] = '{1,  80'hAB000000_000000000000, 0, 1, 1, 1'b0, 1'b0};
        vecs[2] = '{4,  80'hDEADBEEF_000000000000, 3, 2, 2, 1'b0, 1'b0};
        vecs[3] = '{10, 80'h00010203_040506070809, 2, 5, 4, 1'b1, 1'b1};
        vecs[4] = '{7,  80'h01020304_050607000000, 1, 4, 4, 1'b0, 1'b0};
        vecs[5] = '{8,  80'hA1A2A3A4_A5A6A7A80000, 0, 4, 4, 1'b0, 1'b0};
        vecs[6] = '{9,  80'h01020304_050607080900, 2, 5, 4, 1'b1, 1'b1};

        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        i_addr = 16'h0000; i_oe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset; ld_valid alone must not be accepted.
        for (int c = 0; c < 10; c++) begin
            ld_valid = c[0];
            ld_data  = 8'($urandom);
            @(negedge clk);
            chk("idle_outputs",  {cpu_rst, ld_ready, busy, err, ld_count}, {4'b1000, 16'h0});
            chk("idle_outputs4", {cpu_rst4, ld_ready4, busy4, err4, ld_count4}, {4'b1000, 16'h0});
        end
        ld_valid = 1'b0;

        // start together with a valid last byte: the byte is not consumed.
        ld_valid = 1'b1; ld_data = 8'h99; ld_last = 1'b1;
        pulse_start();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("start_wins", {cpu_rst, ld_ready, busy, ld_count}, {3'b111, 16'h0});

        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h56, 1'b0, 0);
        ld_valid = 1'b1; ld_data = 8'h78; ld_last = 1'b1;
        chk("cpu_rst_before_last", 32'(cpu_rst), 32'h1);
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("cpu_rst_after_last", 32'(cpu_rst), 32'h0);
        q = {8'h12, 8'h34, 8'h56, 8'h78};
        check_load(q, "basic");
        i_oe = 1'b1;
        i_addr = 16'h0002; #1; chk("rd_addr2", 32'(i_din), 32'h5678);
        i_addr = 16'h0003; #1; chk("rd_addr3", 32'(i_din), 32'h5678);
        i_oe = 1'b0;       #1; chk("rd_oe0",   32'(i_din), 32'h0);
        @(negedge clk);

        // Single odd byte, then a reload issued from RUN.
        pulse_start();
        send_byte(8'hAB, 1'b1, 0);
        q = {8'hAB};
        check_load(q, "single");
        pulse_start();
        chk("reload_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("reload_ready",   32'(ld_ready), 32'h1);
        chk("reload_cnt",     32'(ld_count), 32'h0);
        send_byte(8'hC3, 1'b1, 1);
        q = {8'hC3};
        check_load(q, "reload");

        foreach (vecs[r]) begin
            q.delete();
            for (int i = 0; i < vecs[r].n; i++) q.push_back(vecs[r].b[79-8*i -: 8]);
            pulse_start();
            for (int i = 0; i < vecs[r].n; i++) begin
                send_byte(q[i], (i == vecs[r].n - 1), vecs[r].maxgap);
                if (i == 7 && vecs[r].n > 8) begin
                    chk("drain_err4",  32'(err4), 32'h1);
                    chk("drain_busy4", {30'h0, busy4, ld_ready4}, 32'h3);
                end
            end
            chk("tbl_cnt",      32'(ld_count),  32'(vecs[r].cnt_big));
            chk("tbl_cnt4",     32'(ld_count4), 32'(vecs[r].cnt_small));
            chk("tbl_err4",     32'(err4),      32'(vecs[r].err_small));
            chk("tbl_cpu_rst4", 32'(cpu_rst4),  32'(vecs[r].cpu_rst_small));
            chk("tbl_cpu_rst",  32'(cpu_rst),   32'h0);
            check_load(q, $sformatf("tbl%0d", r));
        end

        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(1, 12);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            pulse_start();
            send_image(q, 2);
            check_load(q, $sformatf("rnd%0d", t));
        end

        // Asynchronous reset in the middle of a load keeps the words already written.
        q = {8'h12, 8'h34};
        pulse_start();
        send_image(q, 0);
        check_load(q, "preload");
        pulse_start();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_outputs",  {cpu_rst, ld_ready, busy, err, ld_count}, {4'b1000, 16'h0});
        chk("abort_outputs4", {cpu_rst4, ld_ready4, busy4, err4, ld_count4}, {4'b1000, 16'h0});
        i_addr = 16'h0000; i_oe = 1'b1;
        #1;
        chk("abort_retained",  32'(i_din),  32'h1122);
        chk("abort_retained4", 32'(i_din4), 32'h1122);
        i_oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q = {8'h5A, 8'hC3, 8'h7E};
        pulse_start();
        send_image(q, 1);
        check_load(q, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
